counter_load_scheduler: RTL and testbench
=========================================

COUNTER_LOAD_SCHEDULER -- requirements
Module: counter_load_scheduler

Interface
REQ-001 The block SHALL have the parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have the parameter LEN_W, default 4, giving the counter and interval-length width.
REQ-003 The block SHALL have the port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have the port req_i  input  N_REQ  per-requester interval request, level-sensitive.
REQ-006 The block SHALL have the port len_i  input  N_REQ*LEN_W  packed interval lengths; requester i uses slice [i*LEN_W +: LEN_W].
REQ-007 The block SHALL have the port gnt_o  output  N_REQ  one-hot grant pulse, 1 cycle.
REQ-008 The block SHALL have the port done_o  output  N_REQ  one-hot completion pulse, 1 cycle.
REQ-009 The block SHALL have the port busy_o  output  1  high whenever the state is not IDLE.
REQ-010 The block SHALL have the port count_o  output  LEN_W  current value of the shared counter.

Function
REQ-011 The block SHALL contain a 4-state FSM with the states IDLE, LOAD, RUN and DONE.
REQ-012 IDLE SHALL remain IDLE while req_i==0; when any req_i bit is high, the FSM SHALL go to LOAD next cycle and register the winner id and the winner's len_i slice (len_q).
REQ-013 Round-robin arbitration SHALL select the winner as the first set req_i bit at or above rr_ptr, scanning upward and wrapping from N_REQ-1 to 0.
REQ-014 In LOAD, gnt_o[id] SHALL be 1 for exactly that cycle, and the counter SHALL be loaded with (2^LEN_W-1) - len_q; the FSM SHALL then go to RUN.
REQ-015 In RUN, if count == all-ones the FSM SHALL go to DONE; otherwise the counter SHALL increment by 1.
REQ-016 RUN SHALL last exactly len_q+1 cycles, so len_q=0 gives 1 RUN cycle; done_o[id] SHALL assert exactly len_q+2 cycles after gnt_o[id].
REQ-017 In DONE, done_o[id] SHALL be 1 for one cycle, rr_ptr SHALL be set to (id+1) mod N_REQ, and the FSM SHALL go to IDLE.
REQ-018 The counter SHALL hold its value in IDLE and DONE and SHALL never wrap during RUN.
REQ-019 len_i SHALL be sampled only at the IDLE->LOAD transition; later len_i changes SHALL have no effect on the interval in progress.
REQ-020 Deasserting req_i[id] during LOAD or RUN SHALL NOT abort the interval; done_o[id] SHALL still pulse.
REQ-021 req_i changes outside IDLE SHALL be ignored; pending requests SHALL be arbitrated on the next IDLE cycle.
REQ-022 A requester still requesting in the IDLE cycle after its DONE SHALL be re-granted only if no requester at or above rr_ptr is requesting.
REQ-023 At most one bit of gnt_o and at most one bit of done_o SHALL be set in any cycle, and gnt_o and done_o SHALL never both be nonzero in the same cycle.
REQ-024 The minimum turnaround from one DONE to the next LOAD SHALL be 2 cycles, passing through one IDLE cycle.

Reset
REQ-025 While reset is high at a clk edge, the FSM SHALL go to IDLE, with rr_ptr=0, count=0, id=0 and len_q=0.
REQ-026 During and immediately after reset, gnt_o=0, done_o=0, busy_o=0 and count_o=0.
REQ-027 Reset asserted during LOAD or RUN SHALL abort the interval with no done_o pulse.

Structure
REQ-028 The shared package counter_sched_pkg SHALL hold the FSM state enum and the N_REQ and LEN_W defaults.
REQ-029 The counter SHALL be a separate sub-module interval_counter (inputs load_i, load_val_i, en_i; output count_o), in which load takes priority over enable.
REQ-030 The round-robin winner selection SHALL be combinational within counter_load_scheduler, and the FSM, rr_ptr, id and len_q SHALL be registered.

Verification
REQ-031 After reset, req_i=4'b0001 with len0=3 SHALL give gnt_o=0001 at cycle t, count_o 12,13,14,15 during RUN, and done_o=0001 at t+5.
REQ-032 req_i=4'b1111 held continuously with all len=0 SHALL give grant order 0,1,2,3,0, with every done_o exactly 2 cycles after its gnt_o.
REQ-033 With rr_ptr=2 and req_i=4'b0011, requester 0 SHALL be granted first (wrap), then requester 1.
REQ-034 Setting len0=15 and changing len_i[3:0] to 1 during RUN SHALL still give 16 RUN cycles, with done_o 17 cycles after gnt_o.
REQ-035 req_i[2] dropped mid-RUN SHALL still produce a done_o[2] pulse on schedule, with busy_o low on the cycle after it.
REQ-036 Reset asserted mid-RUN SHALL give no done_o, count_o=0 and busy_o=0 on the next cycle, and the next request SHALL be served from rr_ptr=0.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// Shared definitions for the counter load scheduler: default sizes and FSM state encoding.
package counter_sched_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned LEN_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/interval_counter.sv
// Loadable up-counter for the interval timer; load has priority over enable.
//   clk, reset   : clock, synchronous active-high reset (clears count)
//   load_i       : load load_val_i this cycle
//   load_val_i   : value to load
//   en_i         : increment by one when not loading
//   count_o      : current count
module interval_counter
  import counter_sched_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [LEN_W-1:0] load_val_i,
  input  logic             en_i,
  output logic [LEN_W-1:0] count_o
);

  logic [LEN_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (en_i) begin
      count_q <= count_q + LEN_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/counter_load_scheduler.sv
// Round-robin scheduler that grants one requester at a time a timed interval of
// len+1 counter cycles, then signals completion.
//   clk, reset : clock, synchronous active-high reset
//   req_i      : per-requester interval request (level)
//   len_i      : packed per-requester interval lengths, LEN_W bits each
//   gnt_o      : one-hot grant pulse (LOAD cycle)
//   done_o     : one-hot completion pulse (DONE cycle)
//   busy_o     : high while not IDLE
//   count_o    : shared counter value
module counter_load_scheduler
  import counter_sched_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned LEN_W = LEN_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*LEN_W-1:0] len_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic                   busy_o,
  output logic [LEN_W-1:0]       count_o
);

  localparam int unsigned ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_e           state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic             busy_q, busy_d;

  logic [LEN_W-1:0] len_arr [N_REQ];
  logic [ID_W-1:0]  win_id, cand;
  logic             win_valid;
  logic [LEN_W-1:0] count;
  logic             cnt_load, cnt_en, cnt_max;

  // Unpack the per-requester length slices.
  for (genvar g = 0; g < int'(N_REQ); g++) begin : g_len
    assign len_arr[g] = len_i[g*LEN_W +: LEN_W];
  end

  // Round-robin pick: scan downward in offset so the smallest offset from rr_ptr wins.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % int'(N_REQ));
      if (req_i[cand]) begin
        win_valid = 1'b1;
        win_id    = cand;
      end
    end
  end

  assign cnt_max = (count == {LEN_W{1'b1}});

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    len_d    = len_q;
    gnt_d    = '0;
    done_d   = '0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          state_d       = ST_LOAD;
          id_d          = win_id;
          len_d         = len_arr[win_id];
          gnt_d[win_id] = 1'b1;
        end
      end
      ST_LOAD: begin
        cnt_load = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (cnt_max) begin
          state_d      = ST_DONE;
          done_d[id_q] = 1'b1;
        end else begin
          cnt_en = 1'b1;
        end
      end
      ST_DONE: begin
        rr_ptr_d = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + ID_W'(1);
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      id_q     <= '0;
      len_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      len_q    <= len_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  // Loading all-ones minus len (i.e. ~len) makes the count reach all-ones after len increments.
  interval_counter #(
    .LEN_W (LEN_W)
  ) u_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (cnt_load),
    .load_val_i (~len_q),
    .en_i       (cnt_en),
    .count_o    (count)
  );

  assign gnt_o   = gnt_q;
  assign done_o  = done_q;
  assign busy_o  = busy_q;
  assign count_o = count;

endmodule

// File: tb/tb_counter_load_scheduler.sv
// Bench for counter_load_scheduler: timeline model plus directed scenarios.
module tb_counter_load_scheduler;

  localparam int N = 4;
  localparam int W = 4;
  localparam int CMAX = (1 << W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic [N-1:0]     req_i;
  logic [N*W-1:0]   len_i;
  logic [N-1:0]     gnt_o, done_o;
  logic             busy_o;
  logic [W-1:0]     count_o;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  counter_load_scheduler #(.N_REQ(N), .LEN_W(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req_i   (req_i),
    .len_i   (len_i),
    .gnt_o   (gnt_o),
    .done_o  (done_o),
    .busy_o  (busy_o),
    .count_o (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int oh2id(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = N - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  // Timeline model: each interval is a grant cycle g and a done cycle d = g+len+2.
  bit           m_valid = 0;
  int           m_rr, m_g, m_d, m_id, m_len, m_count;
  logic [N-1:0] e_gnt, e_done;
  logic         e_busy;

  always @(posedge clk) begin
    int w;
    bit found;
    cyc++;
    if (reset) begin
      m_valid = 1;
      m_rr = 0; m_g = -100; m_d = -100; m_id = 0; m_len = 0; m_count = 0;
    end else if (m_valid) begin
      if (m_d < cyc - 1 && req_i != '0) begin
        found = 0;
        w = 0;
        for (int k = 0; k < N; k++) begin
          if (!found && req_i[(m_rr + k) % N]) begin
            w = (m_rr + k) % N;
            found = 1;
          end
        end
        m_id  = w;
        m_len = int'((len_i >> (w * W)) & ((1 << W) - 1));
        m_g   = cyc;
        m_d   = cyc + m_len + 2;
      end
      if (cyc == m_d) m_rr = (m_id + 1) % N;
      if (cyc > m_g && cyc < m_d) m_count = CMAX - m_len + (cyc - m_g - 1);
    end
    e_gnt  = (cyc == m_g) ? N'(1 << m_id) : '0;
    e_done = (cyc == m_d) ? N'(1 << m_id) : '0;
    e_busy = (cyc >= m_g && cyc <= m_d);
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("gnt_o", 32'(gnt_o), 32'(e_gnt));
      chk("done_o", 32'(done_o), 32'(e_done));
      chk("busy_o", 32'(busy_o), 32'(e_busy));
      chk("count_o", 32'(count_o), 32'(m_count));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int id, output int at);
    bit seen = 0;
    id = -1; at = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (gnt_o != '0) begin id = oh2id(gnt_o); at = cyc; seen = 1; end
    end
    if (!seen) chk("gnt_timeout", 32'(1), 32'(0));
  endtask

  task automatic wait_done(output int id, output int at);
    bit seen = 0;
    id = -1; at = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (done_o != '0) begin id = oh2id(done_o); at = cyc; seen = 1; end
    end
    if (!seen) chk("done_timeout", 32'(1), 32'(0));
  endtask

  int gq_id[$], gq_cyc[$], dq_id[$], dq_cyc[$];

  // Record grants/dones until n grants are seen (then drop requests) and the block is idle.
  task automatic run_collect(input int n);
    bit fin = 0;
    gq_id.delete(); gq_cyc.delete(); dq_id.delete(); dq_cyc.delete();
    for (int i = 0; i < 200 && !fin; i++) begin
      tick();
      if (gnt_o != '0) begin gq_id.push_back(oh2id(gnt_o)); gq_cyc.push_back(cyc); end
      if (done_o != '0) begin dq_id.push_back(oh2id(done_o)); dq_cyc.push_back(cyc); end
      if (gq_id.size() == n) req_i = '0;
      if (gq_id.size() >= n && !busy_o) fin = 1;
    end
    if (!fin) chk("collect_timeout", 32'(1), 32'(0));
  endtask

  initial begin
    int id, g, d, did;
    int ord3[5] = '{0, 1, 2, 3, 0};
    int ord4[2] = '{0, 1};
    reset = 1'b1; req_i = '0; len_i = '0;
    repeat (3) tick();
    chk("rst_gnt", 32'(gnt_o), 32'(0));
    chk("rst_done", 32'(done_o), 32'(0));
    chk("rst_busy", 32'(busy_o), 32'(0));
    chk("rst_count", 32'(count_o), 32'(0));
    reset = 1'b0;
    tick();

    // Single request, len0=3: count 12..15 during RUN, done 5 cycles after grant.
    req_i = 4'b0001; len_i = 16'h0003;
    wait_gnt(id, g);
    chk("s1_gnt", 32'(gnt_o), 32'(4'b0001));
    req_i = '0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s1_count", 32'(count_o), 32'(12 + k));
    end
    tick();
    chk("s1_done", 32'(done_o), 32'(4'b0001));
    chk("s1_done_lat", 32'(cyc - g), 32'(5));
    tick();
    chk("s1_idle", 32'(busy_o), 32'(0));

    // All requesting, len=0: grant order 0,1,2,3,0, done two cycles after each grant.
    reset = 1'b1; tick(); reset = 1'b0;
    len_i = '0; req_i = 4'b1111;
    run_collect(5);
    for (int i = 0; i < gq_id.size() && i < 5; i++) begin
      chk("s2_order", 32'(gq_id[i]), 32'(ord3[i]));
      if (i < dq_cyc.size()) begin
        chk("s2_done_lat", 32'(dq_cyc[i] - gq_cyc[i]), 32'(2));
        chk("s2_done_id", 32'(dq_id[i]), 32'(gq_id[i]));
      end
      if (i > 0) chk("s2_spacing", 32'(gq_cyc[i] - gq_cyc[i-1]), 32'(4));
    end

    // Move rr_ptr to 2 via requester 1, then 0011 must serve 0 (wrap) then 1.
    req_i = 4'b0010;
    wait_gnt(id, g);
    chk("s3_first", 32'(id), 32'(1));
    req_i = 4'b0011;
    run_collect(2);
    for (int i = 0; i < gq_id.size() && i < 2; i++)
      chk("s3_order", 32'(gq_id[i]), 32'(ord4[i]));

    // len0=15, len changed mid-RUN: still 16 RUN cycles.
    len_i = 16'h000F; req_i = 4'b0001;
    wait_gnt(id, g);
    chk("s4_id", 32'(id), 32'(0));
    req_i = '0;
    tick();
    chk("s4_first_count", 32'(count_o), 32'(0));
    tick();
    len_i = 16'h0001;
    wait_done(did, d);
    chk("s4_done_lat", 32'(d - g), 32'(17));
    chk("s4_done_count", 32'(count_o), 32'(15));
    tick();

    // Requester 2 drops its request mid-RUN; done still on schedule.
    len_i = 16'h0200; req_i = 4'b0100;
    wait_gnt(id, g);
    chk("s5_id", 32'(id), 32'(2));
    tick(); tick();
    req_i = '0;
    wait_done(did, d);
    chk("s5_done_id", 32'(did), 32'(2));
    chk("s5_done_lat", 32'(d - g), 32'(4));
    tick();
    chk("s5_idle", 32'(busy_o), 32'(0));

    // Reset mid-RUN aborts; next request served from rr_ptr=0.
    len_i = 16'h5000; req_i = 4'b1000;
    wait_gnt(id, g);
    chk("s6_id", 32'(id), 32'(3));
    req_i = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("s6_rst_done", 32'(done_o), 32'(0));
    chk("s6_rst_count", 32'(count_o), 32'(0));
    chk("s6_rst_busy", 32'(busy_o), 32'(0));
    reset = 1'b0;
    len_i = '0; req_i = 4'b1010;
    wait_gnt(id, g);
    chk("s6_after_id", 32'(id), 32'(1));
    req_i = '0;
    wait_done(did, d);
    chk("s6_after_done", 32'(did), 32'(1));
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
